// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle multiply/divide sequencer owning HI/LO
//
// Purpose: runs MULT/MULTU/DIV/DIVU on a shared shift-add multiplier /
// restoring divider (one bit per cycle), owns the HI/LO registers, serves
// MTHI/MTLO writes and requests pipeline stalls while a result is pending.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start, op          EX holds a mult/div (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   opa, opb           rs / rt operands
//   abort              pipeline flush, cancels the operation in flight
//   mf_req             EX holds MFHI/MFLO
//   wr_hi, wr_lo       MTHI / MTLO write enables, data on wr_data
//   hi, lo             HI / LO registers
//   busy, done         operation in progress / one-cycle result-written pulse
//   stall_req          hold the front of the pipeline
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             abort,
  input  logic             mf_req,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [WIDTH-1:0] mcand_q;   // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q;  // upper product half, or partial remainder
  logic [WIDTH-1:0] acc_lo_q;  // multiplier / lower product, or dividend / quotient
  logic [CW-1:0]    cnt_q;
  logic             neg_res_q; // product or quotient sign
  logic             neg_rem_q; // remainder follows the dividend sign
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             is_div, is_signed, div_zero;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign div_zero  = is_div && (opb_q == '0);

  assign abs_a = (is_signed && opa_q[WIDTH-1]) ? -opa_q : opa_q;
  assign abs_b = (is_signed && opb_q[WIDTH-1]) ? -opb_q : opb_q;

  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);

  // The shifted remainder can need WIDTH+1 bits (DIVU with a large divisor);
  // when it is >= the divisor the true difference fits WIDTH bits, so a
  // modulo-2^WIDTH subtract is exact in the case it is used.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, mcand_q};
  assign div_sub   = div_shift[WIDTH-1:0] - mcand_q;

  assign prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = (start && !abort) ? S_PREP : S_IDLE;
      S_PREP: begin
        if (abort)         state_d = S_IDLE;
        else if (div_zero) state_d = S_DONE;
        else               state_d = S_CALC;
      end
      S_CALC: begin
        if (abort)                 state_d = S_IDLE;
        else if (cnt_q == CW'(1))  state_d = S_FIX;
      end
      S_FIX:   state_d = abort ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIX);
    done      = (state_q == S_DONE);
    stall_req = busy && (start || mf_req || wr_hi || wr_lo) && !abort;
  end

  // Datapath
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            op_q  <= op;
            opa_q <= opa;
            opb_q <= opb;
          end
        end
        S_PREP: begin
          mcand_q   <= is_div ? abs_b : abs_a;
          acc_lo_q  <= is_div ? abs_a : abs_b;
          acc_hi_q  <= '0;
          cnt_q     <= CW'(WIDTH);
          neg_res_q <= is_signed && (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
          neg_rem_q <= is_signed && opa_q[WIDTH-1];
        end
        S_CALC: begin
          cnt_q <= cnt_q - CW'(1);
          if (is_div) begin
            acc_hi_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
          end else begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result write beats MTHI/MTLO; moves are only taken while not busy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == S_FIX && !abort) begin
      if (is_div) begin
        hi_q <= rem_fix;
        lo_q <= quot_fix;
      end else begin
        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
        lo_q <= prod_fix[WIDTH-1:0];
      end
    end else if (state_q == S_PREP && !abort && div_zero) begin
      hi_q <= opa_q;
      lo_q <= '1;
    end else if (!busy) begin
      if (wr_hi) hi_q <= wr_data;
      if (wr_lo) lo_q <= wr_data;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
